// File: rtl/layer_norm_row_scheduler.sv
// Row scheduler for a LayerNorm datapath: fetches rows from a source buffer,
// hands each to the datapath, and writes the normalized result back.
module layer_norm_row_scheduler #(
  parameter int D_MODEL        = 128,
  parameter int X_WIDTH        = 16,
  parameter int Y_WIDTH        = 16,
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_start_i,
  input  logic [ADDR_WIDTH-1:0]         cmd_src_base_i,
  input  logic [ADDR_WIDTH-1:0]         cmd_dst_base_i,
  input  logic [ADDR_WIDTH:0]           cmd_num_rows_i,
  input  logic                          abort_i,
  output logic                          rd_en_o,
  output logic [ADDR_WIDTH-1:0]         rd_addr_o,
  input  logic [D_MODEL*X_WIDTH-1:0]    rd_data_i,
  output logic                          ln_start_o,
  output logic [D_MODEL*X_WIDTH-1:0]    ln_x_o,
  input  logic                          ln_busy_i,
  input  logic                          ln_done_i,
  input  logic [D_MODEL*Y_WIDTH-1:0]    ln_y_i,
  output logic                          wr_en_o,
  output logic [ADDR_WIDTH-1:0]         wr_addr_o,
  output logic [D_MODEL*Y_WIDTH-1:0]    wr_data_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_timeout_o,
  output logic [ADDR_WIDTH:0]           rows_done_o
);

  localparam int XW = D_MODEL * X_WIDTH;
  localparam int YW = D_MODEL * Y_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_RDWAIT  = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT_LN = 3'd4,
    S_WRITE   = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_src_base;
  logic [ADDR_WIDTH-1:0] r_dst_base;
  logic [ADDR_WIDTH:0]   r_num_rows;
  logic [ADDR_WIDTH:0]   r_rows_done;
  logic [ADDR_WIDTH:0]   w_rows_inc;
  logic [TW-1:0]         r_to_cnt;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic                  r_done;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_to_hit;
  logic                  w_ln_fire;

  assign w_accept   = (r_state == S_IDLE) && cmd_start_i;
  assign w_rows_inc = r_rows_done + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_to_hit   = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_ln_fire  = (r_state == S_ISSUE) && !ln_busy_i && !abort_i;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Abort wins over every other transition except in IDLE and FINISH.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (cmd_start_i) w_next = (cmd_num_rows_i == '0) ? S_FINISH : S_FETCH;
      S_FETCH:   w_next = abort_i ? S_FINISH : S_RDWAIT;
      S_RDWAIT:  w_next = abort_i ? S_FINISH : S_ISSUE;
      S_ISSUE: begin
        if (abort_i)         w_next = S_FINISH;
        else if (!ln_busy_i) w_next = S_WAIT_LN;
      end
      S_WAIT_LN: begin
        if (abort_i)        w_next = S_FINISH;
        else if (ln_done_i) w_next = S_WRITE;
        else if (w_to_hit)  w_next = S_FINISH;
      end
      S_WRITE:   w_next = (abort_i || (w_rows_inc == r_num_rows)) ? S_FINISH : S_FETCH;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src_base  <= '0;
      r_dst_base  <= '0;
      r_num_rows  <= '0;
      r_rows_done <= '0;
      r_to_cnt    <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH);
      if (w_accept) begin
        r_src_base  <= cmd_src_base_i;
        r_dst_base  <= cmd_dst_base_i;
        r_num_rows  <= cmd_num_rows_i;
        r_rows_done <= '0;
        r_err       <= 1'b0;
      end
      if (r_state == S_WRITE) r_rows_done <= w_rows_inc;
      if (r_state == S_ISSUE)        r_to_cnt <= '0;
      else if (r_state == S_WAIT_LN) r_to_cnt <= r_to_cnt + {{(TW-1){1'b0}}, 1'b1};
      if ((r_state == S_WAIT_LN) && !abort_i && !ln_done_i && w_to_hit) r_err <= 1'b1;
    end
  end

  // Row data registers; cleared on reset so no stale row leaks past it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (r_state == S_RDWAIT) r_x <= rd_data_i;
      if ((r_state == S_WAIT_LN) && ln_done_i && !abort_i) r_y <= ln_y_i;
    end
  end

  assign rd_en_o       = (r_state == S_FETCH) && !abort_i;
  assign rd_addr_o     = r_src_base + r_rows_done[ADDR_WIDTH-1:0];
  assign ln_start_o    = w_ln_fire;
  assign ln_x_o        = r_x;
  assign wr_en_o       = (r_state == S_WRITE);
  assign wr_addr_o     = r_dst_base + r_rows_done[ADDR_WIDTH-1:0];
  assign wr_data_o     = r_y;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;
  assign err_timeout_o = r_err;
  assign rows_done_o   = r_rows_done;

endmodule

// File: tb/tb_layer_norm_row_scheduler.sv
// Directed bench for layer_norm_row_scheduler with a source-memory and
// LayerNorm-datapath model driven from the DUT's request outputs.
module tb_layer_norm_row_scheduler;

  localparam int DM  = 128;
  localparam int XWD = 16;
  localparam int YWD = 16;
  localparam int AW  = 6;
  localparam int TO  = 1023;
  localparam int XW  = DM * XWD;
  localparam int YW  = DM * YWD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_start_i = 1'b0;
  logic [AW-1:0] cmd_src_base_i = '0;
  logic [AW-1:0] cmd_dst_base_i = '0;
  logic [AW:0]   cmd_num_rows_i = '0;
  logic          abort_i = 1'b0;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [XW-1:0] rd_data_i;
  logic          ln_start_o;
  logic [XW-1:0] ln_x_o;
  logic          ln_busy_i;
  logic          ln_done_i;
  logic [YW-1:0] ln_y_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [YW-1:0] wr_data_o;
  logic          busy_o, done_o, err_timeout_o;
  logic [AW:0]   rows_done_o;

  layer_norm_row_scheduler #(
    .D_MODEL(DM), .X_WIDTH(XWD), .Y_WIDTH(YWD), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start_i(cmd_start_i),
    .cmd_src_base_i(cmd_src_base_i), .cmd_dst_base_i(cmd_dst_base_i),
    .cmd_num_rows_i(cmd_num_rows_i), .abort_i(abort_i),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .ln_start_o(ln_start_o), .ln_x_o(ln_x_o), .ln_busy_i(ln_busy_i),
    .ln_done_i(ln_done_i), .ln_y_i(ln_y_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_timeout_o),
    .rows_done_o(rows_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int src; int dst; int nrows; int lat;
    int e_rd0; int e_rdl; int e_wr0; int e_wrl; int e_n; int e_rows;
  } vec_t;

  vec_t tbl[4];
  int errors = 0;
  int checks = 0;

  function automatic logic [XW-1:0] src_row(input int a);
    logic [XW-1:0] r;
    for (int e = 0; e < DM; e++) r[e*XWD +: XWD] = XWD'(a * 256 + e + 1);
    return r;
  endfunction

  function automatic logic [YW-1:0] xform(input logic [XW-1:0] x);
    return x ^ {DM{16'h5A3C}};
  endfunction

  // Monitor / model state
  int cyc = 0, n_rd = 0, n_start = 0, n_wr = 0, n_done = 0;
  int last_rd_cyc = 0, last_start_cyc = 0, last_done_cyc = 0;
  int rd_q[$];
  int wa_q[$];
  logic [YW-1:0] wd_q[$];
  logic [XW-1:0] sx_q[$];
  bit s_rd = 0, s_start = 0;
  int s_rd_addr = 0;
  logic [XW-1:0] s_x;
  int dp_cnt = 0, dp_lat = 1;
  bit dp_respond = 1, force_busy = 0;
  logic [XW-1:0] dp_x;

  initial begin
    rd_data_i = {DM{16'hDEAD}};
    ln_busy_i = 1'b0;
    ln_done_i = 1'b0;
    ln_y_i    = {DM{16'hBEEF}};
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_en_o) begin n_rd++; rd_q.push_back(int'(rd_addr_o)); last_rd_cyc = cyc; end
      s_rd = rd_en_o; s_rd_addr = int'(rd_addr_o);
      if (ln_start_o) begin n_start++; last_start_cyc = cyc; sx_q.push_back(ln_x_o); end
      s_start = ln_start_o; s_x = ln_x_o;
      if (wr_en_o) begin n_wr++; wa_q.push_back(int'(wr_addr_o)); wd_q.push_back(wr_data_o); end
      if (done_o) begin n_done++; last_done_cyc = cyc; end
      @(posedge clk);
      #2;
      rd_data_i = s_rd ? src_row(s_rd_addr) : {DM{16'hDEAD}};
      ln_done_i = 1'b0;
      ln_y_i    = {DM{16'hBEEF}};
      if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0 && dp_respond) begin ln_done_i = 1'b1; ln_y_i = xform(dp_x); end
      end
      if (s_start) begin dp_cnt = dp_lat; dp_x = s_x; end
      ln_busy_i = (dp_cnt > 0) || force_busy;
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got low word %h expected low word %h", nm, got[31:0], exp[31:0]);
    end
  endtask

  function automatic int get_cnt(input int sel);
    case (sel)
      0: return n_rd;
      1: return n_start;
      2: return n_wr;
      default: return n_done;
    endcase
  endfunction

  task automatic wait_cnt(input string nm, input int sel, input int target, input int lim);
    int t = 0;
    while (get_cnt(sel) < target && t < lim) begin @(posedge clk); t++; end
    #1;
    checks++;
    if (get_cnt(sel) < target) begin
      errors++;
      $display("FAIL %s: wait expired, count %0d need %0d", nm, get_cnt(sel), target);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_done"}, done_o, 0);
    chk({nm, "_err"}, err_timeout_o, 0);
    chk({nm, "_rows"}, rows_done_o, 0);
    chk({nm, "_rd_en"}, rd_en_o, 0);
    chk({nm, "_rd_addr"}, rd_addr_o, 0);
    chk({nm, "_ln_start"}, ln_start_o, 0);
    chk({nm, "_wr_en"}, wr_en_o, 0);
    chk({nm, "_wr_addr"}, wr_addr_o, 0);
    chkv({nm, "_ln_x"}, ln_x_o, '0);
    chkv({nm, "_wr_data"}, wr_data_o, '0);
  endtask

  task automatic start_job(input int src, input int dst, input int n);
    rd_q.delete(); wa_q.delete(); wd_q.delete(); sx_q.delete();
    @(posedge clk); #1;
    cmd_src_base_i = AW'(src); cmd_dst_base_i = AW'(dst); cmd_num_rows_i = (AW+1)'(n);
    cmd_start_i = 1'b1;
    @(posedge clk); #1;
    cmd_start_i = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input string nm);
    int rd0, wr0, st0, dn0;
    rd0 = n_rd; wr0 = n_wr; st0 = n_start; dn0 = n_done;
    dp_lat = v.lat; dp_respond = 1;
    start_job(v.src, v.dst, v.nrows);
    wait_cnt({nm, "_done_wait"}, 3, dn0 + 1, 2000);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_n_rd"}, n_rd - rd0, v.e_n);
    chk({nm, "_n_start"}, n_start - st0, v.e_n);
    chk({nm, "_n_wr"}, n_wr - wr0, v.e_n);
    chk({nm, "_n_done"}, n_done - dn0, 1);
    chk({nm, "_rows_done"}, rows_done_o, v.e_rows);
    chk({nm, "_busy_end"}, busy_o, 0);
    chk({nm, "_err"}, err_timeout_o, 0);
    if (v.e_n > 0 && rd_q.size() == v.e_n && wa_q.size() == v.e_n && sx_q.size() == v.e_n) begin
      chk({nm, "_rd_first"}, rd_q[0], v.e_rd0);
      chk({nm, "_rd_last"}, rd_q[v.e_n-1], v.e_rdl);
      chk({nm, "_wr_first"}, wa_q[0], v.e_wr0);
      chk({nm, "_wr_last"}, wa_q[v.e_n-1], v.e_wrl);
      for (int i = 0; i < v.e_n; i++) begin
        chk($sformatf("%s_rd_addr%0d", nm, i), rd_q[i], (v.src + i) % 64);
        chk($sformatf("%s_wr_addr%0d", nm, i), wa_q[i], (v.dst + i) % 64);
        chkv($sformatf("%s_ln_x%0d", nm, i), sx_q[i], src_row((v.src + i) % 64));
        chkv($sformatf("%s_wr_data%0d", nm, i), wd_q[i], xform(src_row((v.src + i) % 64)));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, st0, dn0;
    tbl[0] = '{4, 10, 3, 20, 4, 6, 10, 12, 3, 3};
    tbl[1] = '{62, 60, 4, 3, 62, 1, 60, 63, 4, 4};
    tbl[2] = '{0, 63, 2, 1, 0, 1, 63, 0, 2, 2};
    tbl[3] = '{63, 0, 1, 5, 63, 63, 0, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Zero-row job: done two cycles after the start request, no traffic.
    rd0 = n_rd; wr0 = n_wr; st0 = n_start;
    @(posedge clk); #1;
    cmd_src_base_i = 6'd5; cmd_dst_base_i = 6'd7; cmd_num_rows_i = '0; cmd_start_i = 1'b1;
    @(negedge clk); chk("zero_done_c0", done_o, 0);
    @(posedge clk); #1; cmd_start_i = 1'b0;
    @(negedge clk); chk("zero_done_c1", done_o, 0); chk("zero_busy_c1", busy_o, 1);
    @(negedge clk); chk("zero_done_c2", done_o, 1); chk("zero_busy_c2", busy_o, 0);
    @(negedge clk); chk("zero_done_c3", done_o, 0);
    chk("zero_no_rd", n_rd - rd0, 0);
    chk("zero_no_start", n_start - st0, 0);
    chk("zero_no_wr", n_wr - wr0, 0);
    chk("zero_rows", rows_done_o, 0);

    for (int k = 0; k < 4; k++) run_job(tbl[k], $sformatf("job%0d", k));

    // Datapath busy for 5 ISSUE cycles: start fires on the first free cycle.
    rd0 = n_rd; st0 = n_start; dn0 = n_done;
    dp_lat = 4;
    @(posedge clk); #1; force_busy = 1;
    start_job(20, 30, 1);
    wait_cnt("busy_rd_wait", 0, rd0 + 1, 20);
    repeat (6) @(posedge clk);
    #1; force_busy = 0;
    wait_cnt("busy_done_wait", 3, dn0 + 1, 100);
    chk("busy_start_delay", last_start_cyc - last_rd_cyc, 7);
    chk("busy_start_once", n_start - st0, 1);
    chk("busy_rows", rows_done_o, 1);
    if (sx_q.size() == 1) chkv("busy_ln_x", sx_q[0], src_row(20));

    // Datapath never answers: sticky timeout after TO cycles in WAIT_LN.
    rd0 = n_rd; wr0 = n_wr; st0 = n_start; dn0 = n_done;
    dp_respond = 0; dp_lat = 5;
    start_job(40, 50, 2);
    wait_cnt("to_done_wait", 3, dn0 + 1, 1500);
    repeat (5) @(posedge clk);
    #1;
    chk("to_err", err_timeout_o, 1);
    chk("to_latency", last_done_cyc - last_start_cyc, TO + 2);
    chk("to_no_wr", n_wr - wr0, 0);
    chk("to_rows", rows_done_o, 0);
    chk("to_n_rd", n_rd - rd0, 1);
    chk("to_n_start", n_start - st0, 1);
    chk("to_n_done", n_done - dn0, 1);
    dp_respond = 1; dp_lat = 2;
    dn0 = n_done;
    start_job(1, 2, 1);
    chk("to_err_cleared", err_timeout_o, 0);
    wait_cnt("to_next_done", 3, dn0 + 1, 100);

    // Abort while waiting on row index 2; the late ln_done must be ignored.
    rd0 = n_rd; wr0 = n_wr; st0 = n_start; dn0 = n_done;
    dp_lat = 10;
    start_job(8, 16, 4);
    wait_cnt("ab_wait_start", 1, st0 + 3, 200);
    repeat (3) @(posedge clk);
    #1; abort_i = 1'b1;
    @(posedge clk); #1; abort_i = 1'b0;
    wait_cnt("ab_done_wait", 3, dn0 + 1, 50);
    repeat (20) @(posedge clk);
    #1;
    chk("ab_n_wr", n_wr - wr0, 2);
    chk("ab_n_rd", n_rd - rd0, 3);
    chk("ab_n_start", n_start - st0, 3);
    chk("ab_n_done", n_done - dn0, 1);
    chk("ab_rows", rows_done_o, 2);
    chk("ab_busy", busy_o, 0);
    if (wa_q.size() == 2) chk("ab_last_wr", wa_q[1], 17);

    // Reset in the middle of a job clears everything and drops the write.
    st0 = n_start;
    start_job(30, 40, 3);
    wait_cnt("rst_wait_start", 1, st0 + 1, 50);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst_n = 1'b1;
    wr0 = n_wr; dn0 = n_done;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_no_wr", n_wr - wr0, 0);
    chk("midrst_no_done", n_done - dn0, 0);
    chk("midrst_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
